// File: rtl/tx_rs_io.sv
// Transmit-side XGMII reconciliation I/O: serializes 64b+8c words into 32b+4c columns and inserts link-fault sequences.
// Optional fault FSM/counter/override enabled by defining TXRS_FAULT_SEQ_EN; otherwise link_state is always OK.
module tx_rs_io #(
  parameter int LINK_OK_CNT = 128
) (
  input  logic         txclk_2x,
  input  logic         reset,
  input  logic [63:0]  txd64,
  input  logic [7:0]   txc8,
  input  logic         txd64_valid,
  output logic         tx_ready,
  input  logic         local_fault,
  input  logic         remote_fault,
  output logic [0:31]  txd,
  output logic [0:3]   txc,
  output logic [1:0]   link_state
);

  typedef enum logic [1:0] {
    ST_OK = 2'd0,
    ST_LF = 2'd1,
    ST_RF = 2'd2
  } state_t;

  localparam logic [35:0] IDLE_COL  = {32'hE0E0_E0E0, 4'b1111};
  // Remote-fault column: sequence char in lane 0, txd[30] and txd[31] set.
  localparam logic [35:0] FAULT_COL = {32'h5900_0003, 4'b1000};

  state_t      state;
  logic        ph;
  logic [35:0] hold;
  logic [35:0] pair_col0;
  logic [35:0] pair_col1;

`ifdef TXRS_FAULT_SEQ_EN
  localparam logic [15:0] CNT_LAST = 16'(LINK_OK_CNT - 1);

  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;

  always_ff @(posedge txclk_2x) begin
    if (reset) begin
      state <= ST_OK;
      cnt   <= 16'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_OK: begin
        if (local_fault)       state_next = ST_LF;
        else if (remote_fault) state_next = ST_RF;
        cnt_next = 16'd0;
      end
      default: begin
        // Any fresh indication restarts the fault-free run; local wins.
        if (local_fault) begin
          state_next = ST_LF;
          cnt_next   = 16'd0;
        end else if (remote_fault) begin
          state_next = ST_RF;
          cnt_next   = 16'd0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_OK;
          cnt_next   = 16'd0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
    endcase
  end
`else
  localparam int unused_link_ok_cnt = LINK_OK_CNT;
  logic unused_faults;

  assign unused_faults = local_fault ^ remote_fault;
  assign state         = ST_OK;
`endif

  assign link_state = state;
  assign tx_ready   = ~ph & ~reset;

  // Column pair chosen at a phase-0 edge; the override is sampled only here.
  always_comb begin
    pair_col0 = IDLE_COL;
    pair_col1 = IDLE_COL;
    if (state == ST_LF) begin
      pair_col0 = FAULT_COL;
      pair_col1 = FAULT_COL;
    end else if (state == ST_OK && txd64_valid) begin
      pair_col0 = {txd64[31:0],  txc8[3:0]};
      pair_col1 = {txd64[63:32], txc8[7:4]};
    end
  end

  always_ff @(posedge txclk_2x) begin
    if (reset) begin
      ph         <= 1'b0;
      {txd, txc} <= IDLE_COL;
      hold       <= IDLE_COL;
    end else begin
      ph <= ~ph;
      if (!ph) begin
        {txd, txc} <= pair_col0;
        hold       <= pair_col1;
      end else begin
        {txd, txc} <= hold;
      end
    end
  end

endmodule

// File: tb/tb_tx_rs_io.sv
// Directed bench for tx_rs_io: reset, single word, back-to-back with reassembly, faults (when TXRS_FAULT_SEQ_EN), mid-word reset.
module tb_tx_rs_io;

  logic         txclk_2x = 1'b0;
  logic         reset;
  logic [63:0]  txd64;
  logic [7:0]   txc8;
  logic         txd64_valid;
  logic         tx_ready;
  logic         local_fault;
  logic         remote_fault;
  logic [0:31]  txd;
  logic [0:3]   txc;
  logic [1:0]   link_state;

  int total = 0;
  int bad   = 0;
  logic [71:0] exp_q[$];

  localparam logic [35:0] IDLE_COL  = {32'hE0E0_E0E0, 4'hF};
  localparam logic [35:0] FAULT_COL = {32'h5900_0003, 4'h8};

  tx_rs_io #(.LINK_OK_CNT(8)) dut (
    .txclk_2x    (txclk_2x),
    .reset       (reset),
    .txd64       (txd64),
    .txc8        (txc8),
    .txd64_valid (txd64_valid),
    .tx_ready    (tx_ready),
    .local_fault (local_fault),
    .remote_fault(remote_fault),
    .txd         (txd),
    .txc         (txc),
    .link_state  (link_state)
  );

  // clock / watchdog
  always #5 txclk_2x = ~txclk_2x;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver and check tasks
  task automatic tick();
    @(posedge txclk_2x);
    #1;
  endtask

  task automatic mid();
    @(negedge txclk_2x);
  endtask

  task automatic word(input logic [63:0] d, input logic [7:0] c);
    txd64       = d;
    txc8        = c;
    txd64_valid = 1'b1;
  endtask

  function automatic logic [35:0] col();
    return {txd, txc};
  endfunction

  function automatic logic [35:0] c0(input logic [63:0] d, input logic [7:0] c);
    return {d[31:0], c[3:0]};
  endfunction

  function automatic logic [35:0] c1(input logic [63:0] d, input logic [7:0] c);
    return {d[63:32], c[7:4]};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic align();
    for (int k = 0; k < 3 && !tx_ready; k++) tick();
    chk("align_ready", tx_ready, 1);
  endtask

  initial begin
    logic [35:0] prev;
    logic [63:0] d;
    logic [7:0]  c;

    reset        = 1'b1;
    txd64        = 64'hFFFF_0000_FFFF_0000;
    txc8         = 8'hFF;
    txd64_valid  = 1'b1;
    local_fault  = 1'b0;
    remote_fault = 1'b0;
    prev         = '0;

    // reset held three edges with a valid word offered
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
      chk("rst_txd",   txd, 32'hE0E0_E0E0);
      chk("rst_txc",   txc, 4'hF);
      chk("rst_ready", tx_ready, 0);
      chk("rst_link",  link_state, 0);
    end
    reset       = 1'b0;
    txd64_valid = 1'b0;
    #1;
    chk("release_ready", tx_ready, 1);

    // single word
    tick();
    mid();
    chk("pre_idle", col(), IDLE_COL);
    tick();
    align();
    word(64'h1122_3344_AABB_CCDD, 8'h00);
    tick();
    txd64_valid = 1'b0;
    mid();
    chk("single_c0", col(), {32'hAABB_CCDD, 4'h0});
    chk("single_rdy0", tx_ready, 0);
    tick();
    mid();
    chk("single_c1", col(), {32'h1122_3344, 4'h0});
    tick();
    mid();
    chk("single_idle_a", col(), IDLE_COL);
    tick();
    mid();
    chk("single_idle_b", col(), IDLE_COL);

    // back-to-back words, reassembled as the RX side would
    tick();
    align();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        d = 64'hA5A5_0000_5A5A_0000 + {32'(i + 1), 32'(i)};
        c = 8'(8'h13 * (i / 2 + 1));
        word(d, c);
        if (i % 2 == 0) exp_q.push_back({c, d});
      end else begin
        txd64_valid = 1'b0;
      end
      mid();
      chk("b2b_ready", tx_ready, (i % 2 == 0));
      if (i >= 1 && i <= 16) begin
        if (i % 2 == 0) chk("loopback", {txc, prev[3:0], txd, prev[35:4]}, exp_q.pop_front());
        prev = col();
      end
      if (i == 17) chk("b2b_tail_idle", col(), IDLE_COL);
      tick();
    end

`ifdef TXRS_FAULT_SEQ_EN
    // local fault pulse during column 0
    align();
    word(64'h0BAD_F00D_CAFE_BABE, 8'h5A);
    tick();
    txd64_valid = 1'b0;
    local_fault = 1'b1;
    mid();
    chk("lf_c0", col(), c0(64'h0BAD_F00D_CAFE_BABE, 8'h5A));
    tick();
    local_fault = 1'b0;
    word(64'h7777_6666_5555_4444, 8'h3C);
    for (int i = 2; i <= 12; i++) begin
      if (i == 11) txd64_valid = 1'b0;
      mid();
      chk("lf_ready", tx_ready, (i % 2 == 0));
      chk("lf_state", link_state, (i <= 9) ? 2'd1 : 2'd0);
      if (i == 2)       chk("lf_c1", col(), c1(64'h0BAD_F00D_CAFE_BABE, 8'h5A));
      else if (i <= 10) chk("lf_col", col(), FAULT_COL);
      else if (i == 11) chk("lf_resume_c0", col(), c0(64'h7777_6666_5555_4444, 8'h3C));
      else              chk("lf_resume_c1", col(), c1(64'h7777_6666_5555_4444, 8'h3C));
      tick();
    end

    // remote fault for 5 cycles, then local fault while in RF
    align();
    for (int i = 0; i <= 18; i++) begin
      remote_fault = (i <= 4);
      local_fault  = (i == 6);
      if (i == 1)  word(64'h0123_4567_89AB_CDEF, 8'hF0);
      if (i == 17) txd64_valid = 1'b0;
      mid();
      chk("rf_ready", tx_ready, (i % 2 == 0));
      if (i >= 1) chk("rf_state", link_state, (i <= 6) ? 2'd2 : (i <= 14) ? 2'd1 : 2'd0);
      if (i <= 8)       chk("rf_idle", col(), IDLE_COL);
      else if (i <= 16) chk("rf_lf_col", col(), FAULT_COL);
      else if (i == 17) chk("rf_resume_c0", col(), c0(64'h0123_4567_89AB_CDEF, 8'hF0));
      else              chk("rf_resume_c1", col(), c1(64'h0123_4567_89AB_CDEF, 8'hF0));
      tick();
    end
    local_fault  = 1'b0;
    remote_fault = 1'b0;

    // simultaneous faults: local has priority
    align();
    local_fault  = 1'b1;
    remote_fault = 1'b1;
    tick();
    local_fault  = 1'b0;
    remote_fault = 1'b0;
    mid();
    chk("both_state", link_state, 1);
    for (int k = 0; k < 8; k++) tick();
    mid();
    chk("both_recover", link_state, 0);
`else
    // fault inputs have no effect
    align();
    word(64'h0BAD_F00D_CAFE_BABE, 8'h5A);
    tick();
    txd64_valid  = 1'b0;
    local_fault  = 1'b1;
    remote_fault = 1'b1;
    mid();
    chk("nf_c0", col(), c0(64'h0BAD_F00D_CAFE_BABE, 8'h5A));
    tick();
    local_fault  = 1'b0;
    remote_fault = 1'b0;
    mid();
    chk("nf_c1", col(), c1(64'h0BAD_F00D_CAFE_BABE, 8'h5A));
    chk("nf_state", link_state, 0);
`endif

    // reset in the phase-1 cycle drops the pending column 1
    tick();
    align();
    word(64'h2468_ACE0_1357_9BDF, 8'h96);
    tick();
    txd64_valid = 1'b0;
    reset       = 1'b1;
    mid();
    chk("mrst_c0", col(), c0(64'h2468_ACE0_1357_9BDF, 8'h96));
    chk("mrst_ready", tx_ready, 0);
    tick();
    reset = 1'b0;
    mid();
    chk("mrst_idle_a", col(), IDLE_COL);
    chk("mrst_link", link_state, 0);
    chk("mrst_ready_after", tx_ready, 1);
    tick();
    mid();
    chk("mrst_idle_b", col(), IDLE_COL);
    tick();
    mid();
    chk("mrst_idle_c", col(), IDLE_COL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_rs_io.md
# tx_rs_io

Transmit-side XGMII reconciliation I/O block. It accepts 64-bit data with 8 control bits, one word every two cycles, from the MAC transmit engine. It serializes each word into two 32-bit XGMII columns on `txclk_2x`. It also inserts link-fault ordered sets, driven by the fault indications from the receive RS block. On an external loopback, its output is the exact inverse of the receive RS I/O packing.

## Interface
- `LINK_OK_CNT`, default 128: consecutive fault-free cycles required to leave a fault state (range 2..65535; counter width 16).
- `txclk_2x` in 1: the single clock, XGMII column rate.
- `reset` in 1: synchronous, active-high.
- `txd64` in [63:0]: data word; column 0 = `txd64[31:0]`, column 1 = `txd64[63:32]`.
- `txc8` in [7:0]: control; column 0 lane k = `txc8[3-k]`, column 1 lane k = `txc8[7-k]`.
- `txd64_valid` in 1: word present.
- `tx_ready` out 1: word-accept phase; a word transfers when `txd64_valid & tx_ready`.
- `local_fault` in 1: local-fault sequence detected by the RX RS block (single-cycle pulse or level).
- `remote_fault` in 1: remote-fault sequence detected by the RX RS block.
- `txd` out [0:31]: XGMII data; `txd[0:7]` is lane 0; bit order matches the RX RS port.
- `txc` out [0:3]: XGMII control; `txc[0]` is lane 0.
- `link_state` out [1:0]: 0 = OK, 1 = LF (local fault), 2 = RF (remote fault).

## Operation
- Character constants, all in port bit order:
  - IDLE = 8'hE0.
  - SEQUENCE = 8'h59.
- Idle column: `txd` = 32'hE0E0E0E0, `txc` = 4'b1111.
- Fault column:
  - `txd[0:7]` = 8'h59, `txd[8:29]` = 0, `txd[31]` = 1.
  - `txd[30]` = 1 for remote fault; `txc` = 4'b1000.
- Phase register `ph`:
  - Reset value 0; it toggles every cycle after reset.
  - `tx_ready` = `~ph & ~reset`.
- Phase-0 edge, word accepted in state OK:
  - `txd`/`txc` load column 0.
  - Column 1 is stored in a 36-bit hold register.
- Phase-1 edge: `txd`/`txc` load the held column.
- Phase 0 with no valid word: an idle pair is sent (the hold register is loaded with idle).
- In LF or RF, `tx_ready` keeps its phase pattern. Offered words are consumed and discarded, so the MAC never stalls.
- LF output: every column is a remote-fault column (`txd[30]` = 1).
- RF output: every column is idle.
- Fault FSM states and transitions:
  - OK to LF when `local_fault`.
  - OK to RF when `remote_fault` and not `local_fault`. Local fault has priority when both are asserted.
  - In LF or RF, any new fault indication reloads the counter to 0, and re-targets the state (local has priority).
  - Otherwise the counter increments each cycle. At `LINK_OK_CNT`-1 the state returns to OK and the counter clears.
- The FSM updates every cycle. The output override is sampled only at phase-0 edges, so a column pair is never split between data and fault content.
- Reset:
  - `txd`/`txc` go to idle, `ph` = 0, state = OK, counter = 0, `link_state` = 0, hold register = idle.
  - Reset mid-word abandons the pending column 1.

## Timing
- A word accepted in cycle N appears as column 0 on `txd` during cycle N+1 and column 1 during N+2.
- Throughput is one word per two cycles. Back-to-back valid words produce contiguous columns with no idle insertion.
- `link_state` is registered: it reflects a fault in the cycle after the fault input is asserted.
- Fault columns start on the first phase-0 edge after the state change, i.e. within 1–2 cycles. The first override column appears one cycle later.
- Return to OK occurs `LINK_OK_CNT` cycles after the last fault indication. Data resumes at the next phase-0 acceptance.
- All outputs are registered; there is no combinational path from inputs to `txd`/`txc`. `tx_ready` depends only on `ph` and `reset`.

## Configuration
- Macro `TXRS_FAULT_SEQ_EN`.
- When defined: the fault FSM, counter and override are built as described above.
- When undefined:
  - `local_fault`/`remote_fault` are ignored and the state is permanently OK.
  - `link_state` is tied to 2'b00.
  - Valid words are always transmitted.
  - The counter logic is absent.
- `LINK_OK_CNT` has no effect when the macro is undefined.

## Test plan
- **Reset:** assert `reset` 3 cycles with `txd64_valid`=1 → `txd`=32'hE0E0E0E0, `txc`=4'hF, `tx_ready`=0, `link_state`=0. First release cycle → `tx_ready`=1.
- **Single word:** `txd64`=64'h11223344_AABBCCDD, `txc8`=8'h00 accepted in cycle N → `txd`=32'hAABBCCDD at N+1 and 32'h11223344 at N+2, `txc`=4'h0 in both; idle columns afterwards.
- **Back-to-back and loopback:** valid held for 8 words, incrementing data → 16 contiguous columns, no idles, `tx_ready` toggling 1,0. Feeding the outputs into the RX RS block → identical `rxd64`/`rxc8`.
- **Local fault:** with `LINK_OK_CNT`=8, pulse `local_fault` while column 0 of a word is on `txd`:
  - Column 1 is still sent and `link_state`=1.
  - Next pairs are `txd`=32'h59000003, `txc`=4'b1000, and offered words are discarded.
  - 8 cycles after the pulse, `link_state`=0 and data resumes.
- **Remote fault:** hold `remote_fault` 5 cycles → idle columns only, `link_state`=2, `tx_ready` still toggling. Asserting `local_fault` during RF → LF, counter restarts.
- **Simultaneous faults and mid-word reset:** `local_fault` and `remote_fault` together → `link_state`=1. `reset` asserted at a phase-1 cycle → idle on the next cycle, pending column 1 never appears.
